wb_trace_monitor: RTL and testbench
===================================

WB_TRACE_MONITOR -- requirements
Module: wb_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the observed writeback data.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the cycle-stamp width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning trace FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_CYCLES, default 40, meaning the run length in cycles (1..2^CNT_W-1).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  run enable.
REQ-008 SHALL have port wb_valid  input  1  writeback qualifier from the core.
REQ-009 SHALL have port wb_data  input  DATA_W  core writedata.
REQ-010 SHALL have port rd_en  input  1  pop request.
REQ-011 SHALL have port rd_data  output  CNT_W+DATA_W  head entry {stamp, data}, first-word-fall-through.
REQ-012 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port cycle  output  CNT_W  current cycle counter.
REQ-015 SHALL have port overflow  output  1  sticky; a capture was dropped.
REQ-016 SHALL have port done  output  1  high in state DONE.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN when en=1; RUN->DONE on the edge where cycle==MAX_CYCLES-1; DONE->IDLE when en=0; en=0 in RUN -> IDLE.
REQ-018 SHALL clear cycle to 0 on IDLE->RUN, increment by 1 each RUN cycle, and hold in IDLE and DONE (DONE value = MAX_CYCLES).
REQ-019 SHALL, in RUN, push {cycle, wb_data} when wb_valid=1, the stamp being the pre-increment cycle value.
REQ-020 SHALL never capture in IDLE or DONE, including the DONE-entry edge's successor cycles.
REQ-021 SHALL drop a push when the FIFO is full with no simultaneous pop, and set overflow=1.
REQ-022 SHALL pop the head on rd_en=1 when rd_valid=1; rd_en while empty SHALL be ignored.
REQ-023 SHALL, on simultaneous push and pop when full, accept both (count unchanged, no overflow); when empty, accept push only.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL retain FIFO contents and overflow across RUN->DONE->IDLE->RUN; only reset clears them.
REQ-026 SHALL present rd_data = head entry combinationally; value undefined-but-stable (zero) when empty.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, cycle=0, count=0, pointers=0, overflow=0, done=0, rd_valid=0, rd_data=0.
REQ-028 SHALL, on reset asserted mid-RUN, discard all entries; after release remain IDLE until en=1.

Configuration
REQ-029 SHALL support macro WB_TRACE_CHANGE_FILTER_EN; defined: a RUN capture also requires wb_data != last captured data (last-value register reset to 0, first capture after reset always accepted); undefined: every wb_valid in RUN is captured.

Verification
REQ-030 SHALL cover: reset, en=1, wb_valid=1 with wb_data=5 on stamps 0,1,2 -> count=3, pops return {0,5},{1,5},{2,5} (filter off) or only {0,5} (filter on).
REQ-031 SHALL cover: MAX_CYCLES=40, en held 1 -> done=1 after 40 RUN cycles, cycle=40 holds, wb_valid afterwards -> count unchanged.
REQ-032 SHALL cover: DEPTH=8, 9 captures without pops -> count=8, overflow=1, first pop returns stamp 0.
REQ-033 SHALL cover: full FIFO, push and pop same cycle -> count stays 8, overflow stays 0, new entry appears at tail.
REQ-034 SHALL cover: rst=0 pulse asynchronously at cycle 10 with count=4 -> outputs zero immediately, IDLE after release.
REQ-035 SHALL cover: rd_en=1 on empty FIFO -> count stays 0, rd_valid stays 0.

Source files
------------

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: timestamps core writebacks during a bounded run into a FWFT FIFO.
// Optional macro WB_TRACE_CHANGE_FILTER_EN captures only values that differ from the last capture.
module wb_trace_monitor #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wb_valid,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      rd_en,
    output logic [CNT_W+DATA_W-1:0]   rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]          cycle,
    output logic                      overflow,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic empty, full, capture_req, accept, push, pop;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        case (state_q)
            IDLE: if (en) begin
                state_d = RUN;
                cycle_d = '0;
            end
            RUN: if (!en) begin
                state_d = IDLE;
            end else begin
                cycle_d = cycle_q + CNT_W'(1);
                if (cycle_q == CNT_W'(MAX_CYCLES - 1)) state_d = DONE;
            end
            DONE: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_TRACE_CHANGE_FILTER_EN
    logic [DATA_W-1:0] last_q, last_d;
    logic              seen_q, seen_d;

    assign accept = !seen_q || (wb_data != last_q);

    always_comb begin
        last_d = last_q;
        seen_d = seen_q;
        if (push) begin
            last_d = wb_data;
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= '0;
            seen_q <= 1'b0;
        end else begin
            last_q <= last_d;
            seen_q <= seen_d;
        end
    end
`else
    assign accept = 1'b1;
`endif

    assign empty       = (count_q == '0);
    assign full        = (count_q == (AW+1)'(DEPTH));
    assign capture_req = (state_q == RUN) && en && wb_valid && accept;
    assign pop         = rd_en && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = capture_req && (!full || pop);

    always_comb begin
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
        overflow_d = overflow_q | (capture_req && full && !pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cycle_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; empty-gating of rd_data hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {cycle_q, wb_data};
    end

    assign rd_data  = empty ? '0 : mem_q[rptr_q];
    assign rd_valid = !empty;
    assign count    = count_q;
    assign cycle    = cycle_q;
    assign overflow = overflow_q;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed self-checking bench for wb_trace_monitor at default parameters.
module tb_wb_trace_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        rd_en;
    logic [47:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic [15:0] cycle;
    logic        overflow;
    logic        done;

    int checks   = 0;
    int failures = 0;

    wb_trace_monitor dut (
        .clk(clk), .rst(rst), .en(en), .wb_valid(wb_valid), .wb_data(wb_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .cycle(cycle), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart_run();
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; wb_valid = 1'b0; wb_data = '0; rd_en = 1'b0;
        tick(2);
        checks++;
        if ({count, cycle, rd_valid, overflow, done, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got count=%0d cycle=%0d rd_valid=%b ovf=%b done=%b rd_data=%h want all zero",
                     count, cycle, rd_valid, overflow, done, rd_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_capture();
`ifdef WB_TRACE_CHANGE_FILTER_EN
        int n_exp = 1;
`else
        int n_exp = 3;
`endif
        restart_run();
        wb_valid = 1'b1; wb_data = 32'd5;
        tick(3);
        wb_valid = 1'b0;
        checks++;
        if (count !== 4'(n_exp)) begin
            failures++;
            $display("FAIL basic_count got %0d want %0d", count, n_exp);
        end
        checks++;
        if (cycle !== 16'd3) begin
            failures++;
            $display("FAIL basic_cycle got %0d want 3", cycle);
        end
        for (int i = 0; i < n_exp; i++) begin
            checks++;
            if (rd_data !== {16'(i), 32'd5}) begin
                failures++;
                $display("FAIL basic_pop%0d got %h want %h", i, rd_data, {16'(i), 32'd5});
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drained got count=%0d rd_valid=%b want 0/0", count, rd_valid);
        end
    endtask

    task automatic test_run_done();
        restart_run();
        tick(39);
        checks++;
        if (done !== 1'b0 || cycle !== 16'd39) begin
            failures++;
            $display("FAIL done_early got done=%b cycle=%0d want 0/39", done, cycle);
        end
        tick();
        checks++;
        if (done !== 1'b1 || cycle !== 16'd40) begin
            failures++;
            $display("FAIL done_entry got done=%b cycle=%0d want 1/40", done, cycle);
        end
        wb_valid = 1'b1; wb_data = 32'hABC;
        tick(3);
        wb_valid = 1'b0;
        checks++;
        if (count !== 4'd0 || cycle !== 16'd40 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold got count=%0d cycle=%0d done=%b want 0/40/1", count, cycle, done);
        end
        en = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_exit got done=%b want 0", done);
        end
    endtask

    task automatic test_full_push_pop();
        restart_run();
        wb_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wb_data = 32'h20 + 32'(i);
            tick();
        end
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_fill got count=%0d ovf=%b want 8/0", count, overflow);
        end
        wb_data = 32'h99; rd_en = 1'b1;
        tick();
        wb_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop got count=%0d ovf=%b want 8/0", count, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            logic [47:0] exp;
            exp = (i == 8) ? {16'd8, 32'h99} : {16'(i), 32'h20 + 32'(i)};
            checks++;
            if (rd_data !== exp) begin
                failures++;
                $display("FAIL full_drain%0d got %h want %h", i, rd_data, exp);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic test_overflow();
        restart_run();
        wb_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wb_data = 32'h40 + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_state got count=%0d ovf=%b want 8/1", count, overflow);
        end
        checks++;
        if (rd_data !== {16'd0, 32'h40}) begin
            failures++;
            $display("FAIL ovf_head got %h want %h", rd_data, {16'd0, 32'h40});
        end
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick();
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_retain got count=%0d ovf=%b want 8/1", count, overflow);
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        restart_run();
        tick(6);
        wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_data = 32'h60 + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        checks++;
        if (count !== 4'd4 || cycle !== 16'd10) begin
            failures++;
            $display("FAIL midrst_pre got count=%0d cycle=%0d want 4/10", count, cycle);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, cycle, rd_valid, overflow, done, rd_data} !== '0) begin
            failures++;
            $display("FAIL midrst_async got count=%0d cycle=%0d rd_valid=%b rd_data=%h want all zero",
                     count, cycle, rd_valid, rd_data);
        end
        en = 1'b0; wb_valid = 1'b1; wb_data = 32'h77;
        #2;
        rst = 1'b1;
        tick(3);
        wb_valid = 1'b0;
        checks++;
        if (count !== 4'd0 || cycle !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle got count=%0d cycle=%0d done=%b want 0/0/0", count, cycle, done);
        end
    endtask

    task automatic test_empty_pop();
        rd_en = 1'b1;
        tick(3);
        rd_en = 1'b0;
        checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 48'd0) begin
            failures++;
            $display("FAIL empty_pop got count=%0d rd_valid=%b rd_data=%h want 0/0/0", count, rd_valid, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_run_done();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_run();
        test_empty_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
